writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/mips_pkg.sv | 15 +
 rtl/writeback_stage_load_aligner.sv | 35 +++
 rtl/writeback_stage.sv | 100 ++++++++++
 tb/tb_writeback_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and the load-type encoding.
package mips_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  // Encodings 5..7 are reserved and are treated as a full-word load.
  typedef enum logic [2:0] {
    LOAD_LB  = 3'd0,
    LOAD_LH  = 3'd1,
    LOAD_LW  = 3'd2,
    LOAD_LBU = 3'd3,
    LOAD_LHU = 3'd4
  } load_type_e;

endpackage

// File: rtl/writeback_stage_load_aligner.sv
// Extracts and extends the addressed byte/halfword of a raw memory word.
module load_aligner #(
  parameter int unsigned DATA_WIDTH = mips_pkg::DATA_WIDTH
) (
  input  logic [2:0]            load_type,
  input  logic [1:0]            byte_offset,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] load_data
);
  import mips_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Little-endian lane select followed by sign/zero extension.
  always_comb begin
    byte_sel  = '0;
    load_data = mem_data;
    unique case (byte_offset)
      2'd0: byte_sel = mem_data[7:0];
      2'd1: byte_sel = mem_data[15:8];
      2'd2: byte_sel = mem_data[23:16];
      2'd3: byte_sel = mem_data[31:24];
    endcase
    half_sel = byte_offset[1] ? mem_data[31:16] : mem_data[15:0];
    case (load_type)
      LOAD_LB:  load_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      LOAD_LH:  load_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      LOAD_LBU: load_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      LOAD_LHU: load_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default:  load_data = mem_data;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, write-back mux and retired-instruction counter.
module writeback_stage #(
  parameter int unsigned DATA_WIDTH     = mips_pkg::DATA_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_stall,
  input  logic                      i_flush,
  input  logic                      i_valid,
  input  logic                      i_reg_write,
  input  logic                      i_mem_to_reg,
  input  logic                      i_link,
  input  logic [2:0]                i_load_type,
  input  logic [1:0]                i_byte_offset,
  input  logic [DATA_WIDTH-1:0]     i_alu_result,
  input  logic [DATA_WIDTH-1:0]     i_mem_data,
  input  logic [DATA_WIDTH-1:0]     i_link_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_write_register,
  output logic                      o_write_enable,
  output logic [REG_ADDR_WIDTH-1:0] o_write_register,
  output logic [DATA_WIDTH-1:0]     o_write_data,
  output logic [31:0]               o_retired
);
  import mips_pkg::*;

  logic                      valid_q;
  logic                      reg_write_q;
  logic                      mem_to_reg_q;
  logic                      link_q;
  logic [2:0]                load_type_q;
  logic [1:0]                byte_offset_q;
  logic [DATA_WIDTH-1:0]     alu_result_q;
  logic [DATA_WIDTH-1:0]     mem_data_q;
  logic [DATA_WIDTH-1:0]     link_addr_q;
  logic [REG_ADDR_WIDTH-1:0] write_register_q;
  logic [DATA_WIDTH-1:0]     load_data;

  // MEM/WB register: reset clears all, flush kills the slot (beats stall), stall holds.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q          <= 1'b0;
      reg_write_q      <= 1'b0;
      mem_to_reg_q     <= 1'b0;
      link_q           <= 1'b0;
      load_type_q      <= '0;
      byte_offset_q    <= '0;
      alu_result_q     <= '0;
      mem_data_q       <= '0;
      link_addr_q      <= '0;
      write_register_q <= '0;
    end else if (i_flush) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (!i_stall) begin
      valid_q          <= i_valid;
      reg_write_q      <= i_reg_write;
      mem_to_reg_q     <= i_mem_to_reg;
      link_q           <= i_link;
      load_type_q      <= i_load_type;
      byte_offset_q    <= i_byte_offset;
      alu_result_q     <= i_alu_result;
      mem_data_q       <= i_mem_data;
      link_addr_q      <= i_link_addr;
      write_register_q <= i_write_register;
    end
  end

  // An instruction retires when it leaves WB, i.e. the stage is valid and not stalled.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_retired <= '0;
    end else if (valid_q && !i_stall) begin
      o_retired <= o_retired + 32'd1;
    end
  end

  load_aligner #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_aligner (
    .load_type  (load_type_q),
    .byte_offset(byte_offset_q),
    .mem_data   (mem_data_q),
    .load_data  (load_data)
  );

  // Write-back port driven straight from MEM/WB; link beats memory beats ALU.
  always_comb begin
    o_write_enable   = valid_q && reg_write_q && (write_register_q != '0);
    o_write_register = write_register_q;
    if (link_q) begin
      o_write_data = link_addr_q;
    end else if (mem_to_reg_q) begin
      o_write_data = load_data;
    end else begin
      o_write_data = alu_result_q;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with a behavioural model and per-cycle compare.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, valid, reg_write, mem_to_reg, link;
  logic [2:0]  load_type;
  logic [1:0]  byte_offset;
  logic [31:0] alu_result, mem_data, link_addr;
  logic [4:0]  write_register;
  logic        o_we;
  logic [4:0]  o_wr;
  logic [31:0] o_wd;
  logic [31:0] o_retired;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_stage #(
    .DATA_WIDTH    (32),
    .REG_ADDR_WIDTH(5)
  ) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_stall         (stall),
    .i_flush         (flush),
    .i_valid         (valid),
    .i_reg_write     (reg_write),
    .i_mem_to_reg    (mem_to_reg),
    .i_link          (link),
    .i_load_type     (load_type),
    .i_byte_offset   (byte_offset),
    .i_alu_result    (alu_result),
    .i_mem_data      (mem_data),
    .i_link_addr     (link_addr),
    .i_write_register(write_register),
    .o_write_enable  (o_we),
    .o_write_register(o_wr),
    .o_write_data    (o_wd),
    .o_retired       (o_retired)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected write-back value computed arithmetically from the load rules.
  function automatic logic [31:0] exp_data(input bit lk, input bit m2r, input bit [2:0] lt,
                                           input bit [1:0] off, input logic [31:0] alu,
                                           input logic [31:0] mem, input logic [31:0] la);
    logic [31:0] b, h;
    if (lk) return la;
    if (!m2r) return alu;
    b = (mem >> (8 * off)) & 32'hFF;
    h = (mem >> (off[1] ? 16 : 0)) & 32'hFFFF;
    case (lt)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd3:    return b;
      3'd4:    return h;
      default: return mem;
    endcase
  endfunction

  bit          m_init = 1'b0;
  bit          m_known;
  bit          m_valid, m_rw, m_m2r, m_link;
  bit [2:0]    m_lt;
  bit [1:0]    m_off;
  logic [31:0] m_alu, m_mem, m_la;
  logic [4:0]  m_wr;
  logic [31:0] m_count;

  // Model of the stage state, advanced once per rising edge.
  always @(posedge clk) begin
    if (reset) begin
      m_init = 1'b1; m_known = 1'b1;
      m_valid = 0; m_rw = 0; m_m2r = 0; m_link = 0; m_lt = 0; m_off = 0;
      m_alu = 0; m_mem = 0; m_la = 0; m_wr = 0; m_count = 0;
    end else if (m_init) begin
      if (m_valid && !stall) m_count = m_count + 32'd1;
      if (flush) begin
        m_valid = 0; m_rw = 0; m_known = 1'b0;
      end else if (!stall) begin
        m_valid = valid; m_rw = reg_write; m_m2r = mem_to_reg; m_link = link;
        m_lt = load_type; m_off = byte_offset; m_alu = alu_result; m_mem = mem_data;
        m_la = link_addr; m_wr = write_register; m_known = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      cmp("model_we", {31'd0, o_we}, {31'd0, m_valid && m_rw && (m_wr != 5'd0)});
      cmp("model_retired", o_retired, m_count);
      if (m_known) begin
        cmp("model_wr", {27'd0, o_wr}, {27'd0, m_wr});
        cmp("model_wd", o_wd, exp_data(m_link, m_m2r, m_lt, m_off, m_alu, m_mem, m_la));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input bit v, input bit rw, input bit m2r, input bit lk,
                           input bit [2:0] lt, input bit [1:0] off, input logic [31:0] alu,
                           input logic [31:0] mem, input logic [31:0] la, input logic [4:0] wr);
    valid = v; reg_write = rw; mem_to_reg = m2r; link = lk; load_type = lt;
    byte_offset = off; alu_result = alu; mem_data = mem; link_addr = la; write_register = wr;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    set_instr(0, 0, 0, 0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    step(); step();
    cmp("reset_we", {31'd0, o_we}, 32'd0);
    cmp("reset_wr", {27'd0, o_wr}, 32'd0);
    cmp("reset_wd", o_wd, 32'd0);
    cmp("reset_retired", o_retired, 32'd0);
    reset = 1'b0;

    set_instr(1, 1, 1, 0, 3'd0, 2'd2, 32'h11111111, 32'h12803456, 32'h0, 5'd5);
    step();
    cmp("lb_off2", o_wd, 32'hFFFFFF80);
    cmp("lb_we", {31'd0, o_we}, 32'd1);
    cmp("lb_retired", o_retired, 32'd0);

    set_instr(1, 1, 1, 0, 3'd4, 2'd2, 32'h0, 32'h80017FFF, 32'h0, 5'd6);
    step();
    cmp("lhu_off2", o_wd, 32'h00008001);

    set_instr(1, 1, 1, 0, 3'd1, 2'd2, 32'h0, 32'h80017FFF, 32'h0, 5'd6);
    step();
    cmp("lh_off2", o_wd, 32'hFFFF8001);

    set_instr(1, 1, 1, 1, 3'd2, 2'd0, 32'h0, 32'h12345678, 32'h00400008, 5'd31);
    step();
    cmp("link_priority", o_wd, 32'h00400008);

    set_instr(1, 1, 0, 0, 3'd2, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0, 5'd0);
    step();
    cmp("r0_we", {31'd0, o_we}, 32'd0);
    cmp("r0_retired_before", o_retired, 32'd4);

    set_instr(1, 1, 0, 0, 3'd2, 2'd0, 32'hCAFEF00D, 32'h0, 32'h0, 5'd9);
    step();
    cmp("alu_path", o_wd, 32'hCAFEF00D);
    cmp("r0_retired_after", o_retired, 32'd5);

    set_instr(1, 1, 1, 0, 3'd3, 2'd3, 32'h0, 32'hA1B2C3D4, 32'h0, 5'd10);
    step();
    cmp("lbu_off3", o_wd, 32'h000000A1);

    set_instr(1, 1, 1, 0, 3'd6, 2'd1, 32'h0, 32'h87654321, 32'h0, 5'd11);
    step();
    cmp("reserved_lt", o_wd, 32'h87654321);

    set_instr(1, 1, 1, 0, 3'd2, 2'd1, 32'h0, 32'hFEDCBA98, 32'h0, 5'd12);
    step();
    cmp("lw_full", o_wd, 32'hFEDCBA98);
    cmp("retired_8", o_retired, 32'd8);

    set_instr(0, 1, 0, 0, 3'd2, 2'd0, 32'h0, 32'h0, 32'h0, 5'd3);
    step();
    cmp("invalid_we", {31'd0, o_we}, 32'd0);

    set_instr(1, 1, 0, 0, 3'd2, 2'd0, 32'h0000AAAA, 32'h0, 32'h0, 5'd7);
    step();
    cmp("pre_stall_wd", o_wd, 32'h0000AAAA);
    cmp("pre_stall_retired", o_retired, 32'd9);

    stall = 1'b1;
    set_instr(1, 1, 0, 0, 3'd2, 2'd0, 32'h00005555, 32'h0, 32'h0, 5'd8);
    for (int i = 0; i < 3; i++) begin
      step();
      cmp("stall_hold_wd", o_wd, 32'h0000AAAA);
      cmp("stall_hold_wr", {27'd0, o_wr}, 32'd7);
      cmp("stall_hold_we", {31'd0, o_we}, 32'd1);
      cmp("stall_hold_retired", o_retired, 32'd9);
    end
    flush = 1'b1;
    step();
    cmp("flush_we", {31'd0, o_we}, 32'd0);
    cmp("flush_retired", o_retired, 32'd9);
    stall = 1'b0; flush = 1'b0;

    set_instr(1, 1, 0, 0, 3'd2, 2'd0, 32'h00000001, 32'h0, 32'h0, 5'd1);
    step();
    cmp("post_flush_retired", o_retired, 32'd9);
    cmp("post_flush_wd", o_wd, 32'h00000001);

    set_instr(1, 1, 0, 0, 3'd2, 2'd0, 32'h00000002, 32'h0, 32'h0, 5'd2);
    force dut.o_retired = 32'hFFFFFFFF;
    m_count = 32'hFFFFFFFF;
    #1;
    release dut.o_retired;
    #1;
    cmp("preload_retired", o_retired, 32'hFFFFFFFF);
    step();
    cmp("wrap_retired", o_retired, 32'd0);

    reset = 1'b1;
    step();
    cmp("midreset_we", {31'd0, o_we}, 32'd0);
    cmp("midreset_wr", {27'd0, o_wr}, 32'd0);
    cmp("midreset_wd", o_wd, 32'd0);
    cmp("midreset_retired", o_retired, 32'd0);
    reset = 1'b0;
    set_instr(0, 0, 0, 0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    step();
    cmp("after_reset_we", {31'd0, o_we}, 32'd0);
    cmp("after_reset_retired", o_retired, 32'd0);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
